// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tlb_op_ctrl
// Brief   : One-op-at-a-time sequencer for TLBR/TLBWI/TLBWR/TLBP on the MMU
//           maintenance port; owns the CP0 Random register.
//           Optional macro CPU_TLB_RANDOM_ON_RETIRE_EN: Random steps only on
//           retire pulses instead of every clock.
// Revision: 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int INDEX_W     = $clog2(TLB_ENTRIES),
  parameter int ENTRY_W     = 64   // width of one packed TLB entry
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  output logic               op_ready,
  input  logic [INDEX_W-1:0] cp0_index,
  input  logic [INDEX_W-1:0] cp0_wired,
  input  logic               cp0_wired_we,
  input  logic [31:0]        cp0_entry_hi,
  input  logic [ENTRY_W-1:0] op_wdata,
  input  logic               retire,
  output logic [INDEX_W-1:0] cp0_random,
  output logic               done,
  output logic [1:0]         done_type,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [31:0]        probe_result,
  output logic [INDEX_W-1:0] tlbrw_index,
  output logic               tlbrw_we,
  output logic [ENTRY_W-1:0] tlbrw_wdata,
  input  logic [ENTRY_W-1:0] tlbrw_rdata,
  output logic [31:0]        tlbp_entry_hi,
  input  logic [31:0]        tlbp_index
);

  localparam logic [1:0] c_op_tlbr  = 2'b00;
  localparam logic [1:0] c_op_tlbwi = 2'b01;
  localparam logic [1:0] c_op_tlbwr = 2'b10;
  localparam logic [1:0] c_op_tlbp  = 2'b11;

  localparam logic [INDEX_W-1:0] c_random_max = INDEX_W'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_op_ready;
  logic [1:0]         r_type;
  logic               r_done;
  logic [1:0]         r_done_type;
  logic [ENTRY_W-1:0] r_rd_entry;
  logic [31:0]        r_probe_result;
  logic [INDEX_W-1:0] r_tlbrw_index;
  logic               r_tlbrw_we;
  logic [ENTRY_W-1:0] r_tlbrw_wdata;
  logic [31:0]        r_tlbp_entry_hi;
  logic [INDEX_W-1:0] r_random;
  logic               w_step;

`ifdef CPU_TLB_RANDOM_ON_RETIRE_EN
  assign w_step = retire;
`else
  logic w_unused_retire;
  assign w_unused_retire = retire;
  assign w_step          = 1'b1;
`endif

  // Compare-first: a value at or below Wired wraps to the top, so the
  // decrement never underflows and Wired >= max pins Random at max.
  always_ff @(posedge clk) begin
    if (rst || cp0_wired_we) begin
      r_random <= c_random_max;
    end else if (w_step) begin
      if (r_random <= cp0_wired) begin
        r_random <= c_random_max;
      end else begin
        r_random <= r_random - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_op_ready      <= 1'b1;
      r_type          <= c_op_tlbr;
      r_done          <= 1'b0;
      r_done_type     <= 2'b00;
      r_rd_entry      <= '0;
      r_probe_result  <= '0;
      r_tlbrw_index   <= '0;
      r_tlbrw_we      <= 1'b0;
      r_tlbrw_wdata   <= '0;
      r_tlbp_entry_hi <= '0;
    end else begin
      r_done     <= 1'b0;
      r_tlbrw_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_state       <= S_ISSUE;
            r_op_ready    <= 1'b0;
            r_type        <= op_type;
            r_tlbrw_wdata <= op_wdata;
            r_tlbrw_we    <= (op_type == c_op_tlbwi) || (op_type == c_op_tlbwr);
            case (op_type)
              c_op_tlbr, c_op_tlbwi: r_tlbrw_index   <= cp0_index;
              c_op_tlbwr:            r_tlbrw_index   <= r_random;
              default:               r_tlbp_entry_hi <= cp0_entry_hi;
            endcase
          end
        end
        S_ISSUE: begin
          if (r_type == c_op_tlbr) begin
            r_rd_entry <= tlbrw_rdata;
          end
          if (r_type == c_op_tlbp) begin
            r_probe_result <= tlbp_index;
          end
          r_done      <= 1'b1;
          r_done_type <= r_type;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b1;
        end
      endcase
    end
  end

  assign op_ready      = r_op_ready;
  assign cp0_random    = r_random;
  assign done          = r_done;
  assign done_type     = r_done_type;
  assign rd_entry      = r_rd_entry;
  assign probe_result  = r_probe_result;
  assign tlbrw_index   = r_tlbrw_index;
  assign tlbrw_we      = r_tlbrw_we;
  assign tlbrw_wdata   = r_tlbrw_wdata;
  assign tlbp_entry_hi = r_tlbp_entry_hi;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlb_op_ctrl
// Brief   : Self-checking bench for tlb_op_ctrl with an MMU stub and a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tlb_op_ctrl;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int EW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [1:0]    op_type;
  logic          op_ready;
  logic [IW-1:0] cp0_index;
  logic [IW-1:0] cp0_wired;
  logic          cp0_wired_we;
  logic [31:0]   cp0_entry_hi;
  logic [EW-1:0] op_wdata;
  logic          retire;
  logic [IW-1:0] cp0_random;
  logic          done;
  logic [1:0]    done_type;
  logic [EW-1:0] rd_entry;
  logic [31:0]   probe_result;
  logic [IW-1:0] tlbrw_index;
  logic          tlbrw_we;
  logic [EW-1:0] tlbrw_wdata;
  logic [EW-1:0] tlbrw_rdata;
  logic [31:0]   tlbp_entry_hi;
  logic [31:0]   tlbp_index;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .cp0_wired_we(cp0_wired_we), .cp0_entry_hi(cp0_entry_hi),
    .op_wdata(op_wdata), .retire(retire), .cp0_random(cp0_random),
    .done(done), .done_type(done_type), .rd_entry(rd_entry),
    .probe_result(probe_result), .tlbrw_index(tlbrw_index),
    .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index)
  );

  // MMU stub: entry tag (EntryHi match field) lives in bits [63:32].
  logic [EW-1:0] mmu_mem [N];
  always @(posedge clk) if (tlbrw_we) mmu_mem[tlbrw_index] <= tlbrw_wdata;
  assign tlbrw_rdata = mmu_mem[tlbrw_index];
  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--)
      if (mmu_mem[i][63:32] == tlbp_entry_hi) tlbp_index = i;
  end

  // Reference model: tracks each operation as a 3-cycle transaction.
  logic [EW-1:0] gold_mem [N];
  int            m_ph;
  logic [1:0]    m_type, m_dtype;
  logic [IW-1:0] m_idx, m_random, m_pre;
  logic [EW-1:0] m_wd, m_rd;
  logic [31:0]   m_ehi, m_probe;
  logic          m_step;

  function automatic logic [31:0] gold_probe(input logic [31:0] ehi);
    logic [31:0] r;
    r = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--) if (gold_mem[i][63:32] == ehi) r = i;
    return r;
  endfunction

  function automatic logic is_write(input logic [1:0] t);
    return (t == 2'b01) || (t == 2'b10);
  endfunction

  always @(posedge clk) begin
`ifdef CPU_TLB_RANDOM_ON_RETIRE_EN
    m_step = retire;
`else
    m_step = 1'b1;
`endif
    if (m_ph == 1 && is_write(m_type)) gold_mem[m_idx] = m_wd;
    if (rst) begin
      m_ph = 0; m_rd = '0; m_probe = '0; m_dtype = 2'b00; m_random = IW'(N - 1);
    end else begin
      m_pre = m_random;
      if (m_ph == 0) begin
        if (op_valid) begin
          m_ph = 1; m_type = op_type; m_wd = op_wdata;
          if (op_type == 2'b10) m_idx = m_pre;
          else if (op_type != 2'b11) m_idx = cp0_index;
          else m_ehi = cp0_entry_hi;
        end
      end else if (m_ph == 1) begin
        if (m_type == 2'b00) m_rd = gold_mem[m_idx];
        if (m_type == 2'b11) m_probe = gold_probe(m_ehi);
        m_dtype = m_type;
        m_ph = 2;
      end else begin
        m_ph = 0;
      end
      if (cp0_wired_we) m_random = IW'(N - 1);
      else if (m_step) m_random = (int'(m_pre) <= int'(cp0_wired)) ? IW'(N - 1) : IW'(int'(m_pre) - 1);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_ready", 64'(op_ready), 64'(m_ph == 0));
      chk("tlbrw_we", 64'(tlbrw_we), 64'(m_ph == 1 && is_write(m_type)));
      chk("done", 64'(done), 64'(m_ph == 2));
      chk("done_type", 64'(done_type), 64'(m_dtype));
      chk("rd_entry", rd_entry, m_rd);
      chk("probe_result", 64'(probe_result), 64'(m_probe));
      chk("cp0_random", 64'(cp0_random), 64'(m_random));
      if (m_ph == 1 && is_write(m_type)) begin
        chk("tlbrw_index", 64'(tlbrw_index), 64'(m_idx));
        chk("tlbrw_wdata", tlbrw_wdata, m_wd);
      end
      if (m_ph == 1 && m_type == 2'b11) chk("tlbp_entry_hi", 64'(tlbp_entry_hi), 64'(m_ehi));
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Call just after a negedge with the DUT idle; returns in the ISSUE cycle.
  task automatic issue_op(input logic [1:0] t);
    op_valid = 1'b1; op_type = t;
    step();
    op_valid = 1'b0;
  endtask

  localparam logic [EW-1:0] ENT_A = 64'h1234_5000_0000_00AB;
  localparam logic [EW-1:0] ENT_B = 64'hABCD_E000_0000_0C0D;
  localparam logic [EW-1:0] ENT_C = 64'h7777_7000_0000_0777;

  initial begin
    int seq [6];
    seq = '{15, 14, 13, 12, 15, 14};
    for (int i = 0; i < N; i++) begin mmu_mem[i] = '0; gold_mem[i] = '0; end
    m_ph = 0; m_type = 2'b00; m_dtype = 2'b00; m_idx = '0; m_wd = '0;
    m_rd = '0; m_ehi = '0; m_probe = '0; m_random = '0; m_pre = '0; m_step = 1'b0;
    rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; cp0_index = '0; cp0_wired = '0;
    cp0_wired_we = 1'b0; cp0_entry_hi = '0; op_wdata = '0; retire = 1'b1;
    repeat (3) step();

    chk("rst op_ready", 64'(op_ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst done_type", 64'(done_type), 64'd0);
    chk("rst tlbrw_we", 64'(tlbrw_we), 64'd0);
    chk("rst tlbrw_index", 64'(tlbrw_index), 64'd0);
    chk("rst tlbp_entry_hi", 64'(tlbp_entry_hi), 64'd0);
    chk("rst rd_entry", rd_entry, 64'd0);
    chk("rst probe_result", 64'(probe_result), 64'd0);
    chk("rst cp0_random", 64'(cp0_random), 64'd15);
    chk_en = 1'b1;
    rst = 1'b0;

    // TLBWI index 5 <- A
    cp0_index = 4'd5; op_wdata = ENT_A;
    issue_op(2'b01);
    chk("wi we", 64'(tlbrw_we), 64'd1);
    chk("wi index", 64'(tlbrw_index), 64'd5);
    chk("wi ready T+1", 64'(op_ready), 64'd0);
    step();
    chk("wi we T+2", 64'(tlbrw_we), 64'd0);
    chk("wi done", 64'(done), 64'd1);
    chk("wi done_type", 64'(done_type), 64'd1);
    chk("wi ready T+2", 64'(op_ready), 64'd0);
    step();
    chk("wi ready T+3", 64'(op_ready), 64'd1);
    chk("wi done T+3", 64'(done), 64'd0);

    // TLBWI index 9 <- B, then TLBR index 5
    cp0_index = 4'd9; op_wdata = ENT_B;
    issue_op(2'b01); step(); step();
    cp0_index = 4'd5; op_wdata = '0;
    issue_op(2'b00);
    chk("r we", 64'(tlbrw_we), 64'd0);
    step();
    chk("r done", 64'(done), 64'd1);
    chk("r rd_entry", rd_entry, ENT_A);
    chk("r we resp", 64'(tlbrw_we), 64'd0);
    step();

    // TLBP hit and miss
    cp0_entry_hi = 32'h1234_5000;
    issue_op(2'b11); step();
    chk("p hit done_type", 64'(done_type), 64'd3);
    chk("p hit", 64'(probe_result), 64'd5);
    step();
    cp0_entry_hi = 32'h5555_5000;
    issue_op(2'b11); step();
    chk("p miss bit31", 64'(probe_result[31]), 64'd1);
    chk("p miss rd_entry held", rd_entry, ENT_A);
    step();

    // Held request: two back-to-back TLBRs of index 9
    cp0_index = 4'd9; op_valid = 1'b1; op_type = 2'b00;
    repeat (6) step();
    op_valid = 1'b0;
    step();
    chk("held rd_entry", rd_entry, ENT_B);

    // Random sequence with Wired = 12
    cp0_wired = 4'd12; cp0_wired_we = 1'b1;
    step();
    cp0_wired_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("random seq", 64'(cp0_random), 64'(seq[i]));
      step();
    end
    chk("random 13", 64'(cp0_random), 64'd13);
    cp0_wired_we = 1'b1;
    step();
    cp0_wired_we = 1'b0;
    chk("wired_we reload", 64'(cp0_random), 64'd15);
    step();
    chk("random 14", 64'(cp0_random), 64'd14);

    // TLBWR accepted while Random = 14
    op_wdata = ENT_C;
    issue_op(2'b10);
    chk("wr index", 64'(tlbrw_index), 64'd14);
    chk("wr random T+1", 64'(cp0_random), 64'd13);
    chk("wr we", 64'(tlbrw_we), 64'd1);
    step(); step();

    // Wired = 15 pins Random at 15
    cp0_wired = 4'd15; cp0_wired_we = 1'b1;
    step();
    cp0_wired_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("random pinned", 64'(cp0_random), 64'd15);
      step();
    end

    // Reset during ISSUE of a TLBWI
    cp0_wired = 4'd4; retire = 1'b0;
    cp0_index = 4'd3; op_wdata = ENT_C;
    issue_op(2'b01);
    chk("abort we issue", 64'(tlbrw_we), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort we", 64'(tlbrw_we), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort ready", 64'(op_ready), 64'd1);
    chk("abort random", 64'(cp0_random), 64'd15);
    step();
    chk("abort no done", 64'(done), 64'd0);
    chk("abort no we", 64'(tlbrw_we), 64'd0);
    step();
`ifdef CPU_TLB_RANDOM_ON_RETIRE_EN
    chk("no retire random", 64'(cp0_random), 64'd15);
`else
    chk("free-run random", 64'(cp0_random), 64'd13);
`endif
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
